// File: rtl/mysystem_pio_pkg.sv
// Shared constants for the PIO-style input slaves: register word addresses
// and edge-capture condition codes.
package mysystem_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/mysystem_miso_spi_if.sv
// Avalon-MM slave register bus (read latency 1, no wait states).
interface mysystem_miso_spi_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/mysystem_pio_sync.sv
// Two-flop input synchronizer plus a history stage; reports per-bit edges
// of the synchronized value according to EDGE_TYPE.
module mysystem_pio_sync
    import mysystem_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned EDGE_TYPE = EDGE_ANY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] edges
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise      = sync2 & ~prev;
    assign fall      = ~sync2 & prev;
    assign sync_data = sync2;

    always_comb begin
        edges = rise | fall;
        if (EDGE_TYPE == EDGE_RISE) begin
            edges = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edges = fall;
        end
    end

endmodule

// File: rtl/mysystem_miso_spi.sv
// Avalon-MM input port sampling the SPI MISO line (and other slow inputs),
// with per-bit edge capture (W1C) and a maskable level interrupt.
module mysystem_miso_spi
    import mysystem_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned EDGE_TYPE = EDGE_ANY
) (
    input  logic                      clk,
    input  logic                      reset,
    mysystem_miso_spi_if.slave        bus,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);

    logic [1:0]       warm;
    logic [WIDTH-1:0] sync_data;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    mysystem_pio_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .in_port   (in_port),
        .sync_data (sync_data),
        .edges     (edges)
    );

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign wr_bits      = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Edges are ignored until the reset-cleared pipeline has refilled.
    assign cap_set = (warm == 2'd3) ? edges : '0;
    assign cap_clr = (wr_en && bus.address == ADDR_EDGECAP) ? wr_bits : '0;

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = sync_data;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warm         <= '0;
            edge_cap     <= '0;
            irq_mask     <= '0;
            bus.readdata <= '0;
        end else begin
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
            // Set after clear: a capture in the same cycle as its W1C survives.
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
            if (wr_en && bus.address == ADDR_IRQMASK) begin
                irq_mask <= wr_bits;
            end
            bus.readdata <= rd_next;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_mysystem_miso_spi.sv
// Directed bench for mysystem_miso_spi: input-history reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_mysystem_miso_spi;

    localparam int unsigned W  = 1;
    localparam int unsigned ET = 0;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;
    logic         irq;

    mysystem_miso_spi_if bus ();

    mysystem_miso_spi #(
        .WIDTH     (W),
        .EDGE_TYPE (ET)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model: edge index e, inputs seen at each edge, last reset edge.
    int           e        = 0;
    int           last_rst = 0;
    logic [W-1:0] hist [0:4095];
    logic [W-1:0] m_cap;
    logic [W-1:0] m_mask;
    logic [31:0]  m_rd;
    logic         m_irq;
    bit           m_valid  = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] prv;
        logic [W-1:0] det;
        logic [W-1:0] dnow;
        logic [W-1:0] wb;
        logic         wr;
        e = e + 1;
        hist[e] = in_port;
        if (reset) begin
            last_rst = e;
            m_cap    = '0;
            m_mask   = '0;
            m_rd     = '0;
            m_valid  = 1'b1;
        end else begin
            // DATA shows the input from two edges ago once that edge is past reset.
            dnow = (e - 2 > last_rst) ? hist[e-2] : '0;
            det  = '0;
            if (e >= last_rst + 4) begin
                cur = hist[e-2];
                prv = hist[e-3];
                if (ET == 0)      det = cur & ~prv;
                else if (ET == 1) det = ~cur & prv;
                else              det = cur ^ prv;
            end
            case (bus.address)
                2'd0:    m_rd = 32'(dnow);
                2'd2:    m_rd = 32'(m_mask);
                2'd3:    m_rd = 32'(m_cap);
                default: m_rd = '0;
            endcase
            wr = bus.chipselect && !bus.write_n;
            wb = bus.writedata[W-1:0];
            if (wr && bus.address == 2'd3) m_cap = m_cap & ~wb;
            m_cap = m_cap | det;
            if (wr && bus.address == 2'd2) m_mask = wb;
        end
        m_irq = |(m_cap & m_mask);
    end

    // Literal expectation mailbox from the driver to the compare process.
    int          lit_req  = 0;
    int          lit_done = 0;
    string       lit_name;
    logic [31:0] lit_rd;
    logic        lit_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            n_tests = n_tests + 1;
            if (bus.readdata !== m_rd) begin
                n_fail = n_fail + 1;
                $display("FAIL model_rd @%0d: got %h want %h", e, bus.readdata, m_rd);
            end
            n_tests = n_tests + 1;
            if (irq !== m_irq) begin
                n_fail = n_fail + 1;
                $display("FAIL model_irq @%0d: got %b want %b", e, irq, m_irq);
            end
        end
        if (lit_req != lit_done) begin
            lit_done = lit_req;
            n_tests  = n_tests + 1;
            if (bus.readdata !== lit_rd || irq !== lit_irq) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got rd=%h irq=%b want rd=%h irq=%b",
                         lit_name, bus.readdata, irq, lit_rd, lit_irq);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] rd, input logic iq);
        lit_name = name;
        lit_rd   = rd;
        lit_irq  = iq;
        lit_req  = lit_req + 1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        in_port        = '1;
        bus.address    = 2'd3;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick(); tick(); tick();
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            lit("warm_no_edge", 32'h0, 1'b0);
        end
        bus.address = 2'd0;
        tick();
        lit("data_high", 32'h1, 1'b0);

        wr(2'd2, 32'h1);
        lit("mask_prewrite", 32'h0, 1'b0);
        tick();
        lit("mask_rd", 32'h1, 1'b0);

        in_port = '0;
        tick(); tick(); tick(); tick();
        bus.address = 2'd3;
        tick();
        lit("fall_none", 32'h0, 1'b0);

        in_port = '1;
        tick();
        lit("rise_k", 32'h0, 1'b0);
        tick();
        lit("rise_k1", 32'h0, 1'b0);
        tick();
        lit("rise_k2", 32'h0, 1'b1);
        tick();
        lit("rise_rd", 32'h1, 1'b1);

        in_port = '0;
        tick(); tick(); tick(); tick();
        lit("fall_keep", 32'h1, 1'b1);

        wr(2'd3, 32'h0);
        lit("w0_keep", 32'h1, 1'b1);
        tick();
        lit("w0_rd", 32'h1, 1'b1);

        wr(2'd3, 32'h1);
        lit("w1c_edge", 32'h1, 1'b0);
        tick();
        lit("w1c_rd", 32'h0, 1'b0);

        in_port = '1;
        tick();
        tick();
        wr(2'd3, 32'h1);
        lit("win_edge", 32'h0, 1'b1);
        tick();
        lit("win_rd", 32'h1, 1'b1);

        wr(2'd2, 32'h0);
        lit("mask0", 32'h1, 1'b0);
        tick();
        lit("mask0_rd", 32'h0, 1'b0);
        bus.address = 2'd3;
        tick();
        lit("cap_still", 32'h1, 1'b0);

        wr(2'd2, 32'h1);
        lit("mask1", 32'h0, 1'b1);
        wr(2'd1, 32'hFFFF_FFFF);
        lit("rsvd_w", 32'h0, 1'b1);
        tick();
        lit("rsvd_rd", 32'h0, 1'b1);
        wr(2'd0, 32'h0);
        lit("data_w", 32'h1, 1'b1);
        tick();
        lit("data_rd", 32'h1, 1'b1);

        bus.address = 2'd3;
        reset = 1'b1;
        tick();
        lit("rst", 32'h0, 1'b0);
        reset = 1'b0;
        tick();
        lit("rst_cap", 32'h0, 1'b0);
        bus.address = 2'd2;
        tick();
        lit("rst_mask", 32'h0, 1'b0);
        bus.address = 2'd0;
        tick(); tick(); tick();
        lit("rst_data", 32'h1, 1'b0);
        bus.address = 2'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        lit("rst_nofalse", 32'h0, 1'b0);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
